csi_capture_controller: RTL and testbench

Frame-capture sequencer behind the `camera` receiver. It arms on a software request and locks onto one virtual channel. It writes packed 32-bit image words into a frame buffer as consecutive addresses, counts lines, and reports completion and framing errors. It runs in the `clock_p` domain, directly on the receiver's decoded outputs, and supports single-shot and continuous capture.

---
 rtl/csi_capture_pkg.sv | 15 +
 rtl/csi_capture_if.sv | 54 +++++
 rtl/csi_event_decoder.sv | 30 +++
 rtl/csi_capture_controller.sv | 165 ++++++++++++++++
 tb/tb_csi_capture_controller.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csi_capture_pkg.sv
// Shared types and constants for the CSI frame-capture sequencer.
package csi_capture_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StCapture,
    StDone
  } capture_state_t;

  localparam int unsigned ERR_LINES        = 0;
  localparam int unsigned ERR_OVERFLOW     = 1;
  localparam int unsigned ERR_NO_FRAME_END = 2;

endpackage

// File: rtl/csi_capture_if.sv
// Receiver, control and frame-buffer signals of the capture controller.
// frame_timestamp exists only when CSI_CAPTURE_TIMESTAMP_EN is defined.
interface csi_capture_if #(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned LINE_WIDTH    = 12
);
  logic                     interrupt;
  logic                     image_data_enable;
  logic                     frame_start;
  logic                     frame_end;
  logic                     line_start;
  logic                     line_end;
  logic [1:0]               virtual_channel;
  logic [31:0]              image_data;
  logic                     capture_request;
  logic                     continuous;
  logic                     abort;
  logic [1:0]               channel_select;
  logic [LINE_WIDTH-1:0]    expected_lines;
  logic                     error_clear;
  logic                     write_enable;
  logic [ADDRESS_WIDTH-1:0] write_address;
  logic [31:0]              write_data;
  logic                     busy;
  logic                     frame_done;
  logic [LINE_WIDTH-1:0]    line_count;
  logic [2:0]               error_status;
`ifdef CSI_CAPTURE_TIMESTAMP_EN
  logic [31:0]              frame_timestamp;
`endif

  modport master (
`ifdef CSI_CAPTURE_TIMESTAMP_EN
    input  frame_timestamp,
`endif
    output interrupt, image_data_enable, frame_start, frame_end, line_start, line_end,
    output virtual_channel, image_data, capture_request, continuous, abort,
    output channel_select, expected_lines, error_clear,
    input  write_enable, write_address, write_data, busy, frame_done, line_count,
    input  error_status
  );

  modport slave (
`ifdef CSI_CAPTURE_TIMESTAMP_EN
    output frame_timestamp,
`endif
    input  interrupt, image_data_enable, frame_start, frame_end, line_start, line_end,
    input  virtual_channel, image_data, capture_request, continuous, abort,
    input  channel_select, expected_lines, error_clear,
    output write_enable, write_address, write_data, busy, frame_done, line_count,
    output error_status
  );

endinterface

// File: rtl/csi_event_decoder.sv
// Qualifies receiver status against the selected virtual channel and emits
// one-hot strobes; packet type priority is frame start > frame end > line start > line end.
module csi_event_decoder (
  input  logic       interrupt_i,
  input  logic       image_data_enable_i,
  input  logic       frame_start_i,
  input  logic       frame_end_i,
  input  logic       line_start_i,
  input  logic       line_end_i,
  input  logic [1:0] virtual_channel_i,
  input  logic [1:0] channel_select_i,
  output logic       frame_start_o,
  output logic       frame_end_o,
  output logic       line_end_o,
  output logic       data_o
);

  logic vc_match;
  logic short_pkt;

  assign vc_match  = (virtual_channel_i == channel_select_i);
  assign short_pkt = interrupt_i && !image_data_enable_i && vc_match;

  assign frame_start_o = short_pkt && frame_start_i;
  assign frame_end_o   = short_pkt && !frame_start_i && frame_end_i;
  assign line_end_o    = short_pkt && !frame_start_i && !frame_end_i && !line_start_i &&
                         line_end_i;
  assign data_o        = image_data_enable_i && vc_match;

endmodule

// File: rtl/csi_capture_controller.sv
// Frame-capture sequencer: arms on request, captures one virtual channel into a
// frame buffer, counts lines and flags errors. Option: CSI_CAPTURE_TIMESTAMP_EN.
module csi_capture_controller
  import csi_capture_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned LINE_WIDTH    = 12
) (
  input logic        clock_p,
  input logic        reset,
  csi_capture_if.slave bus
);

  localparam logic [ADDRESS_WIDTH-1:0] AddrOne = 1;
  localparam logic [LINE_WIDTH-1:0]    LineOne = 1;

  capture_state_t state_q, state_d;

  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                     full_q, full_d;
  logic [LINE_WIDTH-1:0]    lines_q, lines_d;
  logic [2:0]               err_q, err_d;
  logic                     we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] waddr_q;
  logic [31:0]              wdata_q;
  logic                     busy_q;
  logic                     done_q;

  logic ev_frame_start, ev_frame_end, ev_line_end, ev_data;

  csi_event_decoder u_decoder (
    .interrupt_i         (bus.interrupt),
    .image_data_enable_i (bus.image_data_enable),
    .frame_start_i       (bus.frame_start),
    .frame_end_i         (bus.frame_end),
    .line_start_i        (bus.line_start),
    .line_end_i          (bus.line_end),
    .virtual_channel_i   (bus.virtual_channel),
    .channel_select_i    (bus.channel_select),
    .frame_start_o       (ev_frame_start),
    .frame_end_o         (ev_frame_end),
    .line_end_o          (ev_line_end),
    .data_o              (ev_data)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    full_d  = full_q;
    lines_d = lines_q;
    we_d    = 1'b0;
    // Clear first so an error raised in the same cycle overrides it.
    err_d   = bus.error_clear ? 3'b000 : err_q;

    case (state_q)
      StIdle: begin
        if (bus.capture_request) begin
          state_d = StArmed;
          err_d   = 3'b000;
        end
      end
      StArmed: begin
        if (ev_frame_start) begin
          state_d = StCapture;
          addr_d  = '0;
          full_d  = 1'b0;
          lines_d = '0;
        end
      end
      StCapture: begin
        if (ev_frame_start) begin
          err_d[ERR_NO_FRAME_END] = 1'b1;
          addr_d  = '0;
          full_d  = 1'b0;
          lines_d = '0;
        end else if (ev_frame_end) begin
          if (lines_q != bus.expected_lines) err_d[ERR_LINES] = 1'b1;
          state_d = StDone;
        end else if (ev_line_end) begin
          if (lines_q != '1) lines_d = lines_q + LineOne;
        end else if (ev_data) begin
          if (full_q) begin
            err_d[ERR_OVERFLOW] = 1'b1;
          end else begin
            we_d = 1'b1;
            // The last address is held rather than wrapped; full marks it used.
            if (addr_q == '1) full_d = 1'b1;
            else              addr_d = addr_q + AddrOne;
          end
        end
      end
      StDone: begin
        state_d = bus.continuous ? StArmed : StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (bus.abort) begin
      state_d = StIdle;
      addr_d  = addr_q;
      full_d  = full_q;
      lines_d = lines_q;
      we_d    = 1'b0;
      err_d   = bus.error_clear ? 3'b000 : err_q;
    end
  end

  always_ff @(posedge clock_p or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      full_q  <= 1'b0;
      lines_q <= '0;
      err_q   <= 3'b000;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      full_q  <= full_d;
      lines_q <= lines_d;
      err_q   <= err_d;
      we_q    <= we_d;
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_d == StDone);
      if (we_d) begin
        waddr_q <= addr_q;
        wdata_q <= bus.image_data;
      end
    end
  end

  assign bus.write_enable  = we_q;
  assign bus.write_address = waddr_q;
  assign bus.write_data    = wdata_q;
  assign bus.busy          = busy_q;
  assign bus.frame_done    = done_q;
  assign bus.line_count    = lines_q;
  assign bus.error_status  = err_q;

`ifdef CSI_CAPTURE_TIMESTAMP_EN
  logic [31:0] ts_cnt_q;
  logic [31:0] ts_q;
  logic        fs_accept;

  assign fs_accept = ev_frame_start && !bus.abort &&
                     ((state_q == StArmed) || (state_q == StCapture));

  always_ff @(posedge clock_p or posedge reset) begin
    if (reset) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 32'd1;
      if (fs_accept) ts_q <= ts_cnt_q;
    end
  end

  assign bus.frame_timestamp = ts_q;
`endif

endmodule

// File: tb/tb_csi_capture_controller.sv
// Directed bench for csi_capture_controller: a default-size instance and a
// 4-word instance for overflow, both fed the same receiver stimulus.
module tb_csi_capture_controller;

  logic clock_p = 1'b0;
  logic reset   = 1'b1;
  always #5 clock_p = ~clock_p;

  csi_capture_if #(.ADDRESS_WIDTH(16), .LINE_WIDTH(12)) bus ();
  csi_capture_if #(.ADDRESS_WIDTH(2),  .LINE_WIDTH(12)) bus_s ();

  csi_capture_controller #(.ADDRESS_WIDTH(16), .LINE_WIDTH(12)) dut (
    .clock_p (clock_p),
    .reset   (reset),
    .bus     (bus)
  );

  csi_capture_controller #(.ADDRESS_WIDTH(2), .LINE_WIDTH(12)) dut_s (
    .clock_p (clock_p),
    .reset   (reset),
    .bus     (bus_s)
  );

  assign bus_s.interrupt         = bus.interrupt;
  assign bus_s.image_data_enable = bus.image_data_enable;
  assign bus_s.frame_start       = bus.frame_start;
  assign bus_s.frame_end         = bus.frame_end;
  assign bus_s.line_start        = bus.line_start;
  assign bus_s.line_end          = bus.line_end;
  assign bus_s.virtual_channel   = bus.virtual_channel;
  assign bus_s.image_data        = bus.image_data;
  assign bus_s.capture_request   = bus.capture_request;
  assign bus_s.continuous        = bus.continuous;
  assign bus_s.abort             = bus.abort;
  assign bus_s.channel_select    = bus.channel_select;
  assign bus_s.expected_lines    = bus.expected_lines;
  assign bus_s.error_clear       = bus.error_clear;

  int vectors     = 0;
  int miscompares = 0;

  int unsigned wr_addr[$];
  logic [31:0] wr_data[$];
  int unsigned s_addr[$];
  int          done_cnt;

  always @(negedge clock_p) begin
    if (bus.write_enable === 1'b1) begin
      wr_addr.push_back(int'(bus.write_address));
      wr_data.push_back(bus.write_data);
    end
    if (bus_s.write_enable === 1'b1) s_addr.push_back(int'(bus_s.write_address));
    if (bus.frame_done === 1'b1) done_cnt++;
  end

  task automatic step();
    @(posedge clock_p);
    #1;
  endtask

  task automatic idle_inputs();
    bus.interrupt         = 1'b0;
    bus.image_data_enable = 1'b0;
    bus.frame_start       = 1'b0;
    bus.frame_end         = 1'b0;
    bus.line_start        = 1'b0;
    bus.line_end          = 1'b0;
    bus.virtual_channel   = 2'd0;
    bus.image_data        = 32'h0;
    bus.capture_request   = 1'b0;
    bus.abort             = 1'b0;
    bus.error_clear       = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    wr_addr.delete();
    wr_data.delete();
    s_addr.delete();
    done_cnt = 0;
  endtask

  // kind: 0 frame start, 1 frame end, 2 line start, 3 line end
  task automatic send_short(input logic [1:0] vc, input int kind);
    bus.interrupt       = 1'b1;
    bus.virtual_channel = vc;
    bus.frame_start     = (kind == 0);
    bus.frame_end       = (kind == 1);
    bus.line_start      = (kind == 2);
    bus.line_end        = (kind == 3);
    step();
    idle_inputs();
  endtask

  task automatic send_data(input logic [1:0] vc, input logic [31:0] d);
    bus.image_data_enable = 1'b1;
    bus.virtual_channel   = vc;
    bus.image_data        = d;
    step();
    idle_inputs();
  endtask

  task automatic pulse_request();
    bus.capture_request = 1'b1;
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    bus.continuous     = 1'b0;
    bus.channel_select = 2'd0;
    bus.expected_lines = 12'd0;
    idle_inputs();
    reset = 1'b1;
    step();
    vectors++;
    if ({bus.write_enable, bus.busy, bus.frame_done} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b required 000",
               {bus.write_enable, bus.busy, bus.frame_done});
    end
    vectors++;
    if ({bus.write_address, bus.write_data, bus.line_count, bus.error_status} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: addr %h data %h lines %h err %b required all 0",
               bus.write_address, bus.write_data, bus.line_count, bus.error_status);
    end
    do_reset();
  endtask

  task automatic test_single_shot();
    do_reset();
    bus.channel_select = 2'd0;
    bus.expected_lines = 12'd2;
    bus.continuous     = 1'b0;
    pulse_request();
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_busy: got %b required 1", bus.busy);
    end
    send_short(2'd0, 0);
    for (int l = 0; l < 2; l++) begin
      send_short(2'd0, 2);
      for (int w = 0; w < 3; w++) send_data(2'd0, 32'hA000_0000 | (l << 8) | w);
      send_short(2'd0, 3);
    end
    send_short(2'd0, 1);
    vectors++;
    if (bus.frame_done !== 1'b1) begin
      miscompares++;
      $display("FAIL single_done_timing: got %b required 1", bus.frame_done);
    end
    step();
    vectors++;
    if ({bus.busy, bus.frame_done} !== 2'b00) begin
      miscompares++;
      $display("FAIL single_idle: busy/done got %b required 00", {bus.busy, bus.frame_done});
    end
    vectors++;
    if (wr_addr.size() != 6) begin
      miscompares++;
      $display("FAIL single_count: got %0d writes required 6", wr_addr.size());
    end
    for (int i = 0; i < 6; i++) begin
      logic [31:0] exp;
      exp = 32'hA000_0000 | ((i / 3) << 8) | (i % 3);
      vectors++;
      if (i >= wr_addr.size() || wr_addr[i] != i || wr_data[i] !== exp) begin
        miscompares++;
        $display("FAIL single_write%0d: got addr %0d data %h required addr %0d data %h",
                 i, (i < wr_addr.size()) ? wr_addr[i] : 0,
                 (i < wr_data.size()) ? wr_data[i] : 32'h0, i, exp);
      end
    end
    vectors++;
    if (bus.line_count !== 12'd2 || bus.error_status !== 3'b000 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL single_status: lines %0d err %b done %0d required 2 000 1",
               bus.line_count, bus.error_status, done_cnt);
    end
  endtask

  task automatic test_channel_filter();
    do_reset();
    bus.channel_select = 2'd1;
    bus.expected_lines = 12'd1;
    pulse_request();
    send_short(2'd0, 0);
    send_short(2'd0, 2);
    send_data(2'd0, 32'h0000_DEAD);
    send_data(2'd0, 32'h0000_BEEF);
    send_short(2'd0, 3);
    send_short(2'd0, 1);
    send_short(2'd1, 0);
    send_short(2'd1, 2);
    send_data(2'd1, 32'h1111_0000);
    send_data(2'd0, 32'h0BAD_0BAD);
    send_data(2'd1, 32'h1111_0001);
    send_short(2'd1, 3);
    send_short(2'd1, 1);
    step();
    vectors++;
    if (wr_addr.size() != 2 || wr_addr[0] != 0 || wr_addr[1] != 1 ||
        wr_data[0] !== 32'h1111_0000 || wr_data[1] !== 32'h1111_0001) begin
      miscompares++;
      $display("FAIL filter_writes: got %0d writes, first data %h required 2 writes 11110000",
               wr_addr.size(), (wr_data.size() > 0) ? wr_data[0] : 32'h0);
    end
    vectors++;
    if (done_cnt != 1 || bus.error_status !== 3'b000) begin
      miscompares++;
      $display("FAIL filter_status: done %0d err %b required 1 000", done_cnt, bus.error_status);
    end
  endtask

  task automatic test_line_mismatch();
    do_reset();
    bus.channel_select = 2'd0;
    bus.expected_lines = 12'd3;
    pulse_request();
    send_short(2'd0, 0);
    for (int l = 0; l < 2; l++) begin
      send_short(2'd0, 2);
      send_data(2'd0, 32'h2200_0000 | l);
      send_short(2'd0, 3);
    end
    send_short(2'd0, 1);
    step();
    vectors++;
    if (bus.error_status !== 3'b001 || done_cnt != 1 || bus.line_count !== 12'd2) begin
      miscompares++;
      $display("FAIL mismatch: err %b done %0d lines %0d required 001 1 2",
               bus.error_status, done_cnt, bus.line_count);
    end
    pulse_request();
    vectors++;
    if (bus.error_status !== 3'b000 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL request_clears: err %b busy %b required 000 1", bus.error_status, bus.busy);
    end
    bus.abort = 1'b1;
    step();
    idle_inputs();
  endtask

  task automatic test_overflow();
    do_reset();
    bus.channel_select = 2'd0;
    bus.expected_lines = 12'd1;
    pulse_request();
    send_short(2'd0, 0);
    send_short(2'd0, 2);
    for (int w = 0; w < 6; w++) send_data(2'd0, 32'h3300_0000 | w);
    send_short(2'd0, 3);
    send_short(2'd0, 1);
    step();
    vectors++;
    if (s_addr.size() != 4) begin
      miscompares++;
      $display("FAIL overflow_count: got %0d writes required 4", s_addr.size());
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (i >= s_addr.size() || s_addr[i] != i) begin
        miscompares++;
        $display("FAIL overflow_addr%0d: got %0d required %0d",
                 i, (i < s_addr.size()) ? s_addr[i] : 99, i);
      end
    end
    vectors++;
    if (bus_s.error_status !== 3'b010) begin
      miscompares++;
      $display("FAIL overflow_err: got %b required 010", bus_s.error_status);
    end
  endtask

  task automatic test_continuous_abort();
    do_reset();
    bus.channel_select = 2'd0;
    bus.expected_lines = 12'd1;
    bus.continuous     = 1'b1;
    pulse_request();
    for (int f = 0; f < 2; f++) begin
      send_short(2'd0, 0);
      send_short(2'd0, 2);
      send_data(2'd0, 32'h4400_0000 | (f << 4));
      send_data(2'd0, 32'h4400_0001 | (f << 4));
      send_short(2'd0, 3);
      send_short(2'd0, 1);
      step();
    end
    vectors++;
    if (done_cnt != 2 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL cont_frames: done %0d busy %b required 2 1", done_cnt, bus.busy);
    end
    send_short(2'd0, 0);
    send_short(2'd0, 2);
    send_data(2'd0, 32'h4400_0020);
    bus.abort = 1'b1;
    step();
    idle_inputs();
    send_data(2'd0, 32'h4400_0021);
    send_data(2'd0, 32'h4400_0022);
    send_short(2'd0, 3);
    send_short(2'd0, 1);
    step();
    vectors++;
    if (wr_addr.size() != 5 || bus.busy !== 1'b0 || done_cnt != 2) begin
      miscompares++;
      $display("FAIL abort: writes %0d busy %b done %0d required 5 0 2",
               wr_addr.size(), bus.busy, done_cnt);
    end
    vectors++;
    if (wr_addr.size() < 5 || wr_addr[4] != 0 || wr_data[4] !== 32'h4400_0020) begin
      miscompares++;
      $display("FAIL third_frame_write: got addr %0d required 0",
               (wr_addr.size() > 4) ? wr_addr[4] : 99);
    end
    bus.continuous = 1'b0;
  endtask

  task automatic test_missing_frame_end();
    do_reset();
    bus.channel_select = 2'd2;
    bus.expected_lines = 12'd1;
    pulse_request();
    send_short(2'd2, 0);
    send_short(2'd2, 2);
    send_data(2'd2, 32'h5500_0000);
    send_data(2'd2, 32'h5500_0001);
    bus.error_clear = 1'b1;
    send_short(2'd2, 0);
    send_data(2'd2, 32'h5500_0010);
    vectors++;
    if (bus.write_enable !== 1'b1 || bus.write_address !== 16'd0 ||
        bus.error_status !== 3'b100) begin
      miscompares++;
      $display("FAIL restart: we %b addr %0d err %b required 1 0 100",
               bus.write_enable, bus.write_address, bus.error_status);
    end
    send_short(2'd2, 3);
    send_short(2'd2, 1);
    step();
    vectors++;
    if (bus.error_status !== 3'b100 || done_cnt != 1 || wr_addr.size() != 3) begin
      miscompares++;
      $display("FAIL missing_fe_end: err %b done %0d writes %0d required 100 1 3",
               bus.error_status, done_cnt, wr_addr.size());
    end
    bus.error_clear = 1'b1;
    step();
    idle_inputs();
    vectors++;
    if (bus.error_status !== 3'b000) begin
      miscompares++;
      $display("FAIL error_clear: got %b required 000", bus.error_status);
    end
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_channel_filter();
    test_line_mismatch();
    test_overflow();
    test_continuous_abort();
    test_missing_frame_end();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
